// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU: opcodes, branch
// encodings, the fetch sequencer state type and default bus widths.
package cpu_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int INST_WIDTH_DEF = 16;

  // Opcodes carried in inst[15:12]
  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h1;
  localparam logic [3:0] OP_SW   = 4'h2;
  localparam logic [3:0] OP_BLT  = 4'h3;
  localparam logic [3:0] OP_BGT  = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Branch condition selected by control
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BGT  = 2'b10,
    BR_BLT  = 2'b11
  } branch_t;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_ISSUE  = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory request/ready handshake between the fetch sequencer
// (master) and instruction memory (slave).
interface fetch_sequencer_if
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int INST_WIDTH = INST_WIDTH_DEF
) ();

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_rdata;
  logic                  imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, conditional branch target
// or sequential PC + 2. All sums wrap at the address width; range checking
// is left to the following fetch.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [11:0]           offset,   // inst[11:0] of the current instruction
  input  logic                  jump,
  input  logic [1:0]            branch,
  input  logic                  cmp_eq,
  input  logic                  cmp_lt,
  input  logic                  cmp_gt,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] jump_off;
  logic [ADDR_WIDTH-1:0] branch_off;
  logic                  take_branch;

  // Offsets are word counts, so sign-extend and shift left by one
  assign seq_pc     = pc + ADDR_WIDTH'(2);
  assign jump_off   = {{(ADDR_WIDTH-13){offset[11]}}, offset, 1'b0};
  assign branch_off = {{(ADDR_WIDTH-9){offset[7]}}, offset[7:0], 1'b0};

  // Evaluate the branch condition against the comparator flags
  always_comb begin
    take_branch = 1'b0;
    case (branch)
      BR_BEQ:  take_branch = cmp_eq;
      BR_BGT:  take_branch = cmp_gt;
      BR_BLT:  take_branch = cmp_lt;
      default: take_branch = 1'b0;
    endcase
  end

  // Jump has priority if control ever asserts both jump and branch
  always_comb begin
    next_pc = seq_pc;
    if (jump) begin
      next_pc = seq_pc + jump_off;
    end else if (take_branch) begin
      next_pc = seq_pc + branch_off;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch and PC sequencing unit. Fetches one instruction per
// FETCH/ISSUE pair over the imem handshake, presents it to control during
// ISSUE and advances the PC from control's jump/branch/halt response.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    INST_WIDTH = INST_WIDTH_DEF,
  parameter int                    IMEM_BYTES = 512,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_sequencer_if.master     imem,
  output logic [3:0]            op_code,
  output logic [3:0]            func_code,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  jump,
  input  logic                  halt,
  input  logic [1:0]            branch,
  input  logic                  cmp_eq,
  input  logic                  cmp_lt,
  input  logic                  cmp_gt,
  input  logic                  stall,
  output logic                  inst_memory_exception,
  output logic                  halted
);

  fetch_state_t          state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [INST_WIDTH-1:0] inst_reg, inst_next;
  logic                  exc_reg, exc_next;
  logic [ADDR_WIDTH-1:0] target_pc;
  logic                  pc_in_range;

  // Compare one bit wider so an IMEM_BYTES of 2^ADDR_WIDTH still works
  assign pc_in_range = ({1'b0, pc_reg} < (ADDR_WIDTH+1)'(IMEM_BYTES));

  next_pc_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc_calc (
    .pc      (pc_reg),
    .offset  (inst_reg[11:0]),
    .jump    (jump),
    .branch  (branch),
    .cmp_eq  (cmp_eq),
    .cmp_lt  (cmp_lt),
    .cmp_gt  (cmp_gt),
    .next_pc (target_pc)
  );

  // State, PC, instruction latch and sticky exception flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      inst_reg  <= '0;
      exc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      exc_reg   <= exc_next;
    end
  end

  // Next-state logic: fetch, issue with halt > stall > advance, park in HALTED
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    exc_next   = exc_reg;
    case (state_reg)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (!pc_in_range) begin
          // No request goes out; hand control a zero word plus the flag so it halts
          exc_next   = 1'b1;
          inst_next  = '0;
          state_next = ST_ISSUE;
        end else if (imem.imem_ready) begin
          inst_next  = imem.imem_rdata;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (halt) begin
          state_next = ST_HALTED;
        end else if (!stall) begin
          pc_next    = target_pc;
          state_next = ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decode straight from registered state, so
  // reset clears them without waiting for a clock edge
  assign imem.imem_req          = (state_reg == ST_FETCH) && pc_in_range;
  assign imem.imem_addr         = pc_reg;
  assign inst_valid             = (state_reg == ST_ISSUE);
  assign halted                 = (state_reg == ST_HALTED);
  assign inst_memory_exception  = exc_reg;
  assign pc                     = pc_reg;
  assign inst                   = inst_reg;
  assign op_code                = inst_reg[15:12];
  assign func_code              = inst_reg[3:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. The bench plays both instruction
// memory and the control unit; expected values are hand-computed.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  op_code;
  logic [3:0]  func_code;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] pc;
  logic        jump;
  logic        halt;
  logic [1:0]  branch;
  logic        cmp_eq;
  logic        cmp_lt;
  logic        cmp_gt;
  logic        stall;
  logic        inst_memory_exception;
  logic        halted;
  logic        ready_drv;
  logic [15:0] mem [0:255];

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_sequencer_if #(.ADDR_WIDTH(16), .INST_WIDTH(16)) bus ();

  fetch_sequencer #(
    .ADDR_WIDTH (16),
    .INST_WIDTH (16),
    .IMEM_BYTES (512),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .imem                  (bus),
    .op_code               (op_code),
    .func_code             (func_code),
    .inst                  (inst),
    .inst_valid            (inst_valid),
    .pc                    (pc),
    .jump                  (jump),
    .halt                  (halt),
    .branch                (branch),
    .cmp_eq                (cmp_eq),
    .cmp_lt                (cmp_lt),
    .cmp_gt                (cmp_gt),
    .stall                 (stall),
    .inst_memory_exception (inst_memory_exception),
    .halted                (halted)
  );

  // Instruction memory model: word-addressed array, data always presented
  always_comb begin
    bus.imem_rdata = 16'h0000;
    if (bus.imem_addr < 16'd512) bus.imem_rdata = mem[bus.imem_addr[8:1]];
  end
  assign bus.imem_ready = ready_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case the run stalls somewhere unforeseen
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rst_before;
    bit          ready;     // imem_ready driven during this cycle
    bit          req;
    logic [15:0] addr;
    bit          valid;
    logic [15:0] pc;
    logic [15:0] inst;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    jump = 1'b0; halt = 1'b0; branch = 2'b00; stall = 1'b0;
    cmp_eq = 1'b0; cmp_lt = 1'b0; cmp_gt = 1'b0;
  endtask

  // Reset held across two edges, released on a falling edge (start of cycle 0)
  task automatic do_reset();
    clear_ctrl();
    ready_drv = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_issue(input logic [15:0] target, input string name);
    int n;
    n = 0;
    while (!(inst_valid && pc == target) && n < 100) begin
      step();
      n++;
    end
    check(name, {31'b0, (inst_valid && pc == target)}, 32'd1);
  endtask

  initial begin
    bit any_req;
    rst_n = 1'b0;
    ready_drv = 1'b0;
    clear_ctrl();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0100 + 16'(i * 16);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req",   {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_halted",{31'b0, halted}, 32'd0);
    check("rst_exc",   {31'b0, inst_memory_exception}, 32'd0);
    check("rst_pc",    {16'b0, pc}, 32'h0);
    check("rst_inst",  {16'b0, inst}, 32'h0);
    check("rst_op",    {28'b0, op_code}, 32'h0);
    check("rst_func",  {28'b0, func_code}, 32'h0);

    // Sequential fetch with ready held high
    vecs.push_back('{1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h0000, 16'h0100});
    vecs.push_back('{0, 1, 1, 16'h0002, 0, 16'h0002, 16'h0100});
    vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h0002, 16'h0110});
    vecs.push_back('{0, 1, 1, 16'h0004, 0, 16'h0004, 16'h0110});
    vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h0004, 16'h0120});
    vecs.push_back('{0, 1, 1, 16'h0006, 0, 16'h0006, 16'h0120});
    vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h0006, 16'h0130});
    // Three wait states at pc=4
    vecs.push_back('{1, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000});
    vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h0000, 16'h0100});
    vecs.push_back('{0, 1, 1, 16'h0002, 0, 16'h0002, 16'h0100});
    vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h0002, 16'h0110});
    vecs.push_back('{0, 0, 1, 16'h0004, 0, 16'h0004, 16'h0110});
    vecs.push_back('{0, 0, 1, 16'h0004, 0, 16'h0004, 16'h0110});
    vecs.push_back('{0, 0, 1, 16'h0004, 0, 16'h0004, 16'h0110});
    vecs.push_back('{0, 1, 1, 16'h0004, 0, 16'h0004, 16'h0110});
    vecs.push_back('{0, 1, 0, 16'h0000, 1, 16'h0004, 16'h0120});
    vecs.push_back('{0, 1, 1, 16'h0006, 0, 16'h0006, 16'h0120});

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      step();
      check($sformatf("v%0d_req", i), {31'b0, bus.imem_req}, {31'b0, vecs[i].req});
      if (vecs[i].req)
        check($sformatf("v%0d_addr", i), {16'b0, bus.imem_addr}, {16'b0, vecs[i].addr});
      check($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].valid});
      check($sformatf("v%0d_pc", i), {16'b0, pc}, {16'b0, vecs[i].pc});
      check($sformatf("v%0d_inst", i), {16'b0, inst}, {16'b0, vecs[i].inst});
      $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h inst=%h", i,
               bus.imem_req, bus.imem_addr, inst_valid, pc, inst);
      ready_drv = vecs[i].ready;
    end

    // Branches: BEQ at pc=10 with offset 8'hFC (-4 words)
    mem[5] = {OP_BEQ, 4'h1, 8'hFC};
    do_reset();
    run_to_issue(16'h000A, "beq1_reach");
    check("beq_opcode", {28'b0, op_code}, {28'b0, OP_BEQ});
    branch = 2'b01; cmp_eq = 1'b1;
    step();
    clear_ctrl();
    check("beq_taken_req",  {31'b0, bus.imem_req}, 32'd1);
    check("beq_taken_addr", {16'b0, bus.imem_addr}, 32'h0004);
    $display("beq taken: next fetch %h", bus.imem_addr);
    run_to_issue(16'h000A, "beq2_reach");
    branch = 2'b01; cmp_eq = 1'b0; cmp_lt = 1'b1; cmp_gt = 1'b1;
    step();
    clear_ctrl();
    check("beq_not_taken_addr", {16'b0, bus.imem_addr}, 32'h000C);
    $display("beq not taken: next fetch %h", bus.imem_addr);
    mem[5] = {OP_BLT, 4'h1, 8'hFC};
    do_reset();
    run_to_issue(16'h000A, "blt_reach");
    check("blt_opcode", {28'b0, op_code}, {28'b0, OP_BLT});
    branch = 2'b11; cmp_gt = 1'b1;
    step();
    clear_ctrl();
    check("blt_not_taken_addr", {16'b0, bus.imem_addr}, 32'h000C);
    $display("blt with gt only: next fetch %h", bus.imem_addr);

    // Jump to 0x20, then JMP at 0x20 held by a 2-cycle stall
    mem[0]    = {OP_JMP, 12'h00F};
    mem[16]   = {OP_JMP, 12'h010};
    mem[8'h21] = {OP_JMP, 12'h0DE};
    do_reset();
    run_to_issue(16'h0000, "jmp0_reach");
    jump = 1'b1;
    step();
    clear_ctrl();
    check("jmp0_addr", {16'b0, bus.imem_addr}, 32'h0020);
    run_to_issue(16'h0020, "jmp20_reach");
    jump = 1'b1; stall = 1'b1;
    step();
    check("stall1_valid", {31'b0, inst_valid}, 32'd1);
    check("stall1_pc",    {16'b0, pc}, 32'h0020);
    step();
    check("stall2_valid", {31'b0, inst_valid}, 32'd1);
    check("stall2_inst",  {16'b0, inst}, {16'b0, OP_JMP, 12'h010});
    stall = 1'b0;
    step();
    clear_ctrl();
    check("jmp20_req",  {31'b0, bus.imem_req}, 32'd1);
    check("jmp20_addr", {16'b0, bus.imem_addr}, 32'h0042);
    $display("jump after stall: next fetch %h", bus.imem_addr);

    // Jump to 0x200 with a conflicting branch asserted; jump must win
    run_to_issue(16'h0042, "jmp42_reach");
    jump = 1'b1; branch = 2'b01; cmp_eq = 1'b1;
    step();
    clear_ctrl();
    check("oor_pc",  {16'b0, pc}, 32'h0200);
    check("oor_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    check("oor_valid", {31'b0, inst_valid}, 32'd1);
    check("oor_exc",   {31'b0, inst_memory_exception}, 32'd1);
    check("oor_inst",  {16'b0, inst}, 32'h0);
    check("pre_halt_halted", {31'b0, halted}, 32'd0);
    halt = 1'b1;
    step();
    clear_ctrl();
    check("halted_set",   {31'b0, halted}, 32'd1);
    check("halted_valid", {31'b0, inst_valid}, 32'd0);
    ready_drv = 1'b1;
    jump = 1'b1;
    any_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      any_req = any_req | bus.imem_req;
    end
    clear_ctrl();
    check("halt_no_req",  {31'b0, any_req}, 32'd0);
    check("halt_hold",    {31'b0, halted}, 32'd1);
    check("exc_sticky",   {31'b0, inst_memory_exception}, 32'd1);
    $display("halted: pc=%h exc=%0b", pc, inst_memory_exception);

    // Asynchronous reset from HALTED clears status between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_halted", {31'b0, halted}, 32'd0);
    check("arst_exc",    {31'b0, inst_memory_exception}, 32'd0);
    check("arst_pc",     {16'b0, pc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-fetch with ready low
    step();
    check("mf_req1", {31'b0, bus.imem_req}, 32'd1);
    ready_drv = 1'b0;
    step();
    check("mf_req2", {31'b0, bus.imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mf_arst_req",    {31'b0, bus.imem_req}, 32'd0);
    check("mf_arst_valid",  {31'b0, inst_valid}, 32'd0);
    check("mf_arst_halted", {31'b0, halted}, 32'd0);
    check("mf_arst_exc",    {31'b0, inst_memory_exception}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_drv = 1'b1;
    check("mf_cycle0_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    check("mf_restart_req",  {31'b0, bus.imem_req}, 32'd1);
    check("mf_restart_addr", {16'b0, bus.imem_addr}, 32'h0000);
    check("mf_restart_inst", {16'b0, inst}, 32'h0);
    $display("restart after reset: fetch %h", bus.imem_addr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
